// File: rtl/pb_pkg.sv
// Shared picture-buffer types: patch geometry, pixel/patch typedefs and reader states.
package pb_pkg;

    localparam int CW = 10;
    localparam int W  = 16;
    localparam int H  = 16;

    localparam int R = 0;
    localparam int G = 1;
    localparam int B = 2;

    typedef logic [CW-1:0] pixel_t;
    typedef pixel_t [0:2][0:H-1][0:W-1] patch_t;

    typedef enum logic [2:0] {
        PR_IDLE,
        PR_WAIT_OK,
        PR_FETCH,
        PR_SNAP,
        PR_STREAM,
        PR_DONE
    } pr_state_e;

endpackage

// File: rtl/patch_accum.sv
// Per-channel running sums over one streamed patch, plus the held result registers.
module patch_accum #(
    parameter int CW = 10,
    parameter int SW = 18
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clr,
    input  logic          i_en,
    input  logic          i_load,
    input  logic [CW-1:0] i_r,
    input  logic [CW-1:0] i_g,
    input  logic [CW-1:0] i_b,
    output logic [SW-1:0] o_sum_r,
    output logic [SW-1:0] o_sum_g,
    output logic [SW-1:0] o_sum_b
);

    logic [SW-1:0] acc_r, acc_g, acc_b;
    logic [SW-1:0] add_r, add_g, add_b;

    assign add_r = acc_r + SW'(i_r);
    assign add_g = acc_g + SW'(i_g);
    assign add_b = acc_b + SW'(i_b);

    // The result registers take the sum including the final pixel, so they are
    // valid in the same cycle the reader reports done.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_r   <= '0;
            acc_g   <= '0;
            acc_b   <= '0;
            o_sum_r <= '0;
            o_sum_g <= '0;
            o_sum_b <= '0;
        end else begin
            if (i_clr) begin
                acc_r <= '0;
                acc_g <= '0;
                acc_b <= '0;
            end else if (i_en) begin
                acc_r <= add_r;
                acc_g <= add_g;
                acc_b <= add_b;
            end
            if (i_load) begin
                o_sum_r <= add_r;
                o_sum_g <= add_g;
                o_sum_b <= add_b;
            end
        end
    end

endmodule

// File: rtl/patch_reader.sv
// Fetches one frozen patch from the picture buffer and streams it in raster order
// over valid/ready while accumulating per-channel sums.
//
// state      | meaning
// IDLE       | waiting for a start request
// WAIT_OK    | waiting for the buffer to report a complete patch
// FETCH      | one-cycle fetch strobe to the buffer
// SNAP       | buffer settles; counters, accumulators and first pixel are loaded
// STREAM     | pixels offered on valid/ready
// DONE       | one-cycle end-of-patch pulse, sums valid
import pb_pkg::*;

module patch_reader #(
    parameter int W  = 16,
    parameter int H  = 16,
    parameter int CW = 10,
    parameter int SW = CW + $clog2(W*H)
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst_n,
    input  logic                                 i_start,
    input  logic                                 i_oktofetch,
    output logic                                 o_fetch,
    input  logic [0:2][0:H-1][0:W-1][CW-1:0]     i_buf,
    output logic [CW-1:0]                        o_R,
    output logic [CW-1:0]                        o_G,
    output logic [CW-1:0]                        o_B,
    output logic [$clog2(W)-1:0]                 o_x,
    output logic [$clog2(H)-1:0]                 o_y,
    output logic                                 o_valid,
    input  logic                                 i_ready,
    output logic [SW-1:0]                        o_sum_R,
    output logic [SW-1:0]                        o_sum_G,
    output logic [SW-1:0]                        o_sum_B,
    output logic                                 o_done,
    output logic                                 o_busy
);

    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);

    pr_state_e     state, state_nx;
    logic          hs, last;
    logic [XW-1:0] x_nx;
    logic [YW-1:0] y_nx;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= PR_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            PR_IDLE:    if (i_start) state_nx = PR_WAIT_OK;
            PR_WAIT_OK: if (i_oktofetch) state_nx = PR_FETCH;
            PR_FETCH:   state_nx = PR_SNAP;
            PR_SNAP:    state_nx = PR_STREAM;
            PR_STREAM:  if (last) state_nx = PR_DONE;
            PR_DONE:    state_nx = PR_IDLE;
            default:    state_nx = PR_IDLE;
        endcase
    end

    assign o_fetch = (state == PR_FETCH);
    assign o_valid = (state == PR_STREAM);
    assign o_done  = (state == PR_DONE);
    assign o_busy  = (state != PR_IDLE);

    assign hs   = o_valid && i_ready;
    assign last = hs && (o_x == XW'(W-1)) && (o_y == YW'(H-1));

    always_comb begin
        x_nx = o_x + XW'(1);
        y_nx = o_y;
        if (o_x == XW'(W-1)) begin
            x_nx = '0;
            y_nx = o_y + YW'(1);
        end
    end

    // Payload only moves on a handshake, which keeps it stable under backpressure.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_x <= '0;
            o_y <= '0;
            o_R <= '0;
            o_G <= '0;
            o_B <= '0;
        end else if (state == PR_SNAP) begin
            o_x <= '0;
            o_y <= '0;
            o_R <= i_buf[R][0][0];
            o_G <= i_buf[G][0][0];
            o_B <= i_buf[B][0][0];
        end else if (hs && !last) begin
            o_x <= x_nx;
            o_y <= y_nx;
            o_R <= i_buf[R][y_nx][x_nx];
            o_G <= i_buf[G][y_nx][x_nx];
            o_B <= i_buf[B][y_nx][x_nx];
        end
    end

    patch_accum #(
        .CW (CW),
        .SW (SW)
    ) u_accum (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (state == PR_SNAP),
        .i_en    (hs),
        .i_load  (last),
        .i_r     (o_R),
        .i_g     (o_G),
        .i_b     (o_B),
        .o_sum_r (o_sum_R),
        .o_sum_g (o_sum_G),
        .o_sum_b (o_sum_B)
    );

endmodule

// File: tb/tb_patch_reader.sv
// Directed bench for patch_reader: raster order, sums, fetch timing, backpressure, reset.
module tb_patch_reader;
    import pb_pkg::*;

    localparam int SW = CW + $clog2(W*H);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          ok = 1'b0;
    logic          ready = 1'b0;
    patch_t        buf_s;
    logic          fetch, valid, done, busy;
    logic [CW-1:0] dut_r, dut_g, dut_b;
    logic [3:0]    px, py;
    logic [SW-1:0] sr, sg, sb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    patch_reader dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_oktofetch (ok),
        .o_fetch     (fetch),
        .i_buf       (buf_s),
        .o_R         (dut_r),
        .o_G         (dut_g),
        .o_B         (dut_b),
        .o_x         (px),
        .o_y         (py),
        .o_valid     (valid),
        .i_ready     (ready),
        .o_sum_R     (sr),
        .o_sum_G     (sg),
        .o_sum_B     (sb),
        .o_done      (done),
        .o_busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill_ramp();
        for (int c = 0; c < 3; c++)
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++)
                    buf_s[c][y][x] = CW'(c*256 + y*16 + x);
    endtask

    task automatic fill_const(input int v);
        for (int c = 0; c < 3; c++)
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++)
                    buf_s[c][y][x] = CW'(v);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {28'd0, fetch, valid, done, busy}, 0);
        check({tag, "_xy"}, {24'd0, px, py}, 0);
        check({tag, "_rgb"}, {2'd0, dut_r, dut_g, dut_b}, 0);
        check({tag, "_sum"}, {14'd0, sr | sg | sb}, 0);
    endtask

    // One patch read; time t is the cycle number relative to the start edge (cycle 0).
    task automatic run_patch(input int ok_delay, input bit rnd_ready, input bit extra_start,
                             input int reset_at, input int er, input int eg, input int eb);
        int t, hs, fetches, fetch_t, dones, done_t, stalls, xx, yy, exp_fetch;
        bit prev_stall, rdy;
        logic [7:0]  held_xy;
        logic [29:0] held_rgb;
        hs = 0; fetches = 0; fetch_t = -1; dones = 0; done_t = -1; stalls = 0;
        prev_stall = 1'b0; held_xy = '0; held_rgb = '0;
        exp_fetch = (ok_delay == 0) ? 2 : ok_delay + 1;
        ok = (ok_delay == 0);
        ready = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t = 1;
        check("busy_after_start", {31'd0, busy}, 1);
        while (t < 2000) begin
            if (fetch) begin
                fetches++;
                fetch_t = t;
            end
            if (ok_delay > 0 && t == ok_delay) ok = 1'b1;
            if (extra_start) start = (t == 10 || t == 100);
            rdy = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (valid) begin
                if (prev_stall) begin
                    check("hold_xy", {24'd0, px, py}, {24'd0, held_xy});
                    check("hold_rgb", {2'd0, dut_r, dut_g, dut_b}, {2'd0, held_rgb});
                end
                if (reset_at >= 0 && hs == reset_at) begin
                    rst_n = 1'b0;
                    #1;
                    check_all_zero("rst_mid");
                    @(posedge clk); #1;
                    rst_n = 1'b1;
                    ready = 1'b0;
                    ok = 1'b0;
                    start = 1'b0;
                    return;
                end
                ready = rdy;
                if (rdy) begin
                    xx = hs % W;
                    yy = hs / W;
                    check("pix_xy", {24'd0, px, py}, {24'd0, 4'(xx), 4'(yy)});
                    check("pix_rgb", {2'd0, dut_r, dut_g, dut_b},
                          {2'd0, buf_s[R][yy][xx], buf_s[G][yy][xx], buf_s[B][yy][xx]});
                    hs++;
                    prev_stall = 1'b0;
                end else begin
                    stalls++;
                    prev_stall = 1'b1;
                    held_xy = {px, py};
                    held_rgb = {dut_r, dut_g, dut_b};
                end
            end else begin
                ready = rdy;
                prev_stall = 1'b0;
            end
            if (done) begin
                dones++;
                done_t = t;
                check("sum_r", {14'd0, sr}, er);
                check("sum_g", {14'd0, sg}, eg);
                check("sum_b", {14'd0, sb}, eb);
                check("hs_at_done", hs, 256);
                check("done_cycle", t, exp_fetch + 258 + stalls);
            end
            if (dones > 0 && t == done_t + 1)
                check("idle_after_done", {30'd0, busy, valid}, 0);
            if (dones > 0 && t >= done_t + 20) break;
            @(posedge clk); #1;
            t++;
        end
        check("fetch_count", fetches, 1);
        check("fetch_cycle", fetch_t, exp_fetch);
        check("done_count", dones, 1);
        start = 1'b0;
        ready = 1'b0;
    endtask

    initial begin
        fill_ramp();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_patch(0, 1'b0, 1'b0, -1, 32640, 98176, 163712);
        run_patch(20, 1'b0, 1'b1, -1, 32640, 98176, 163712);
        run_patch(0, 1'b1, 1'b0, -1, 32640, 98176, 163712);

        fill_const(1023);
        run_patch(0, 1'b0, 1'b0, -1, 261888, 261888, 261888);

        fill_ramp();
        run_patch(0, 1'b0, 1'b0, 100, 0, 0, 0);
        run_patch(0, 1'b0, 1'b0, -1, 32640, 98176, 163712);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/patch_reader.md
# patch_reader

Consumer end of the picture-buffer interface. On request, it waits for the buffer's `oktofetch` indication and issues a single-cycle `fetch`. It then reads the frozen 3×16×16 patch and streams the pixels in raster order over a valid/ready port. While streaming it accumulates per-channel sums, which downstream tracking logic uses for centroid and template statistics.

## Interface
Parameters:
- `W`, 16, patch width in pixels.
- `H`, 16, patch height in pixels.
- `CW`, 10, channel width in bits.
- `SW`, `CW+$clog2(W*H)` (18), sum width.

Ports:
- `i_clk`  in  1  clock; all logic on the rising edge.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_start`  in  1  request one patch read; sampled only in IDLE.
- `i_oktofetch`  in  1  buffer holds a complete patch.
- `o_fetch`  out  1  one-cycle fetch strobe to the buffer.
- `i_buf`  in  CW×[0:2][0:H-1][0:W-1]  patch array; index order is [channel R,G,B][y][x].
- `o_R`, `o_G`, `o_B`  out  CW each  current pixel.
- `o_x`  out  $clog2(W)  coordinate of the current pixel.
- `o_y`  out  $clog2(H)  coordinate of the current pixel.
- `o_valid`  out  1  pixel valid.
- `i_ready`  in  1  downstream accepts the pixel.
- `o_sum_R`, `o_sum_G`, `o_sum_B`  out  SW each  channel sums of the last completed patch.
- `o_done`  out  1  one-cycle end-of-patch pulse.
- `o_busy`  out  1  state is not IDLE.

## Operation
States and transitions:
- **IDLE → WAIT_OK** on `i_start`.
- **WAIT_OK → FETCH** on the edge where `i_oktofetch`=1. WAIT_OK waits indefinitely.
- **FETCH**: `o_fetch`=1 for exactly this cycle. Always goes to SNAP.
- **SNAP**: one settle cycle. The buffer updates `i_buf` on the fetch edge. Clears the x/y counters and the accumulators. Always goes to STREAM.
- **STREAM**:
  - `o_valid`=1 continuously.
  - `o_R`/`o_G`/`o_B` equal `i_buf[c][y][x]`, registered from the counters.
  - On each `o_valid && i_ready`:
    - add the pixel to all three accumulators (zero-extended to SW);
    - advance x, wrapping at W-1 and then incrementing y.
  - The handshake at (W-1,H-1) goes to DONE.
- **DONE**:
  - `o_done`=1 for one cycle.
  - Accumulators are copied to `o_sum_*` and held until the next DONE.
  - Goes to IDLE.

Rules:
- **Payload stability:** pixel outputs, `o_x` and `o_y` stay stable while `o_valid` && !`i_ready`. Each pixel is emitted exactly once; no drops, no duplicates.
- **Buffer contract:** the upstream buffer holds `i_buf` stable from the edge after fetch until the next fetch. Only this block issues fetch, so no shadow copy is kept.
- **Ignored start:** `i_start` outside IDLE has no effect and is not queued.
- **No overflow:** SW is chosen so the sum cannot overflow. The maximum is (2^CW−1)·W·H = 261888.
- **Reset:** asserting `i_rst_n`=0 at any time, including mid-stream, forces:
  - state IDLE;
  - all outputs 0, including `o_sum_*`;
  - counters and accumulators 0.

## Timing
- **Cycle numbering:** cycle 0 is the edge sampling `i_start`=1 in IDLE.
- **With `i_oktofetch` already high:**
  - WAIT_OK in cycle 1.
  - `o_fetch`=1 in cycle 2.
  - SNAP in cycle 3.
  - First `o_valid` in cycle 4, carrying pixel (0,0).
- **Pixel rate:** with `i_ready` held high, one pixel per cycle, cycles 4..259.
- **End of patch:** `o_done` in cycle 260, with `o_sum_*` valid in the same cycle. IDLE in cycle 261.
- **Earliest restart:** an `i_start` in cycle 261 starts the next read.
- **Fetch latency:** `o_fetch` is asserted exactly one cycle after WAIT_OK first sees `i_oktofetch`=1.
- **Backpressure:** each cycle of `i_ready`=0 delays DONE by one cycle.

## Structure
- **Shared package `pb_pkg`:**
  - `CW`, `W`, `H`;
  - the pixel typedef `logic [CW-1:0]`;
  - the patch typedef `pixel_t [0:2][0:H-1][0:W-1]`;
  - the `pr_state_e` enum;
  - the channel index constants R=0, G=1, B=2.
- **Sub-module `patch_accum`:** a natural split. It holds the three SW-bit accumulators with clear and enable, plus the sum output registers.
- **Top level:** the FSM, raster counters and the pixel output register stay in `patch_reader`.

## Test plan
- **Basic read:**
  - Stimulus: `i_buf[c][y][x]` = c·256+y·16+x; `i_oktofetch`=1; `i_ready`=1.
  - Check one `o_fetch` in cycle 2.
  - Check 256 pixels in raster order, matching the pattern.
  - Check `o_sum_R`=32640, `o_sum_G`=98176, `o_sum_B`=163712, with `o_done` in cycle 260.
- **Delayed oktofetch:**
  - Stimulus: `i_oktofetch` rises 20 cycles after start.
  - Check `o_fetch` stays 0 until then, then pulses exactly one cycle later.
- **Backpressure:**
  - Stimulus: `i_ready` pseudo-random at 50%.
  - Check payload is held stable while stalled.
  - Check exactly 256 handshakes, same sums as the basic read, and `o_done` only after the last handshake.
- **Saturation:**
  - Stimulus: all pixels = 1023.
  - Check every `o_sum_*` = 261888 with no wrap.
- **Ignored start:**
  - Stimulus: `i_start` pulses during WAIT_OK and STREAM.
  - Check no extra `o_fetch` and no extra `o_done`.
- **Reset mid-stream:**
  - Stimulus: assert `i_rst_n`=0 at pixel 100.
  - Check all outputs are 0 immediately.
  - Then a new start yields a full 256-pixel stream and correct sums.
